// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command sequencer for the 8-bit ALU: collects opcode/operand/function
// frames, pulses ALU enable, and returns the 16-bit result LSB-first. Optional
// saturating drop counter is enabled by defining ALU_CTRL_DROP_CNT_EN.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] OPC_ALU_OPER  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] OPC_ALU_NOPER = 8'hDD
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
`ifdef ALU_CTRL_DROP_CNT_EN
  output logic [7:0]              DROP_CNT,
`endif
  output logic                    BUSY
);

  // TX handshake: a byte moves on a cycle where TX_VALID and TX_READY are both
  // high; TX_VALID and TX_DATA are held unchanged until that cycle.

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, EXEC, CAPTURE, SEND_LSB, SEND_MSB
  } state_t;

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    fun_ok;

  // A function byte is legal only if the bits above the function field are clear.
  assign fun_ok = (RX_DATA[DATA_WIDTH-1:FUN_WIDTH] == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      ALU_EN   <= 1'b0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      result   <= '0;
    end else begin
      ALU_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == OPC_ALU_OPER) begin
              state <= GET_A;
              BUSY  <= 1'b1;
            end else if (RX_DATA == OPC_ALU_NOPER) begin
              state <= GET_FUN;
              BUSY  <= 1'b1;
            end
          end
        end
        GET_A: begin
          if (RX_VALID) begin
            ALU_A <= RX_DATA;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (RX_VALID) begin
            ALU_B <= RX_DATA;
            state <= GET_FUN;
          end
        end
        GET_FUN: begin
          if (RX_VALID) begin
            if (fun_ok) begin
              ALU_FUN <= RX_DATA[FUN_WIDTH-1:0];
              ALU_EN  <= 1'b1;
              state   <= EXEC;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        EXEC: state <= CAPTURE;
        CAPTURE: begin
          // The ALU registers its result on the EXEC edge, so it is valid here.
          result   <= ALU_OUT;
          TX_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
          TX_VALID <= 1'b1;
          state    <= SEND_LSB;
        end
        SEND_LSB: begin
          if (TX_READY) begin
            TX_DATA <= result[2*DATA_WIDTH-1:DATA_WIDTH];
            state   <= SEND_MSB;
          end
        end
        SEND_MSB: begin
          if (TX_READY) begin
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_CTRL_DROP_CNT_EN
  logic drop;

  always_comb begin
    drop = 1'b0;
    if (RX_VALID) begin
      case (state)
        IDLE:    drop = (RX_DATA != OPC_ALU_OPER) && (RX_DATA != OPC_ALU_NOPER);
        GET_FUN: drop = !fun_ok;
        EXEC, CAPTURE, SEND_LSB, SEND_MSB: drop = 1'b1;
        default: drop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      DROP_CNT <= 8'd0;
    else if (drop && (DROP_CNT != 8'hFF))
      DROP_CNT <= DROP_CNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: behavioural registered ALU, RX byte driver,
// TX scoreboard fed from an expected-byte queue, and one task per scenario.
module tb_alu_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
`ifdef ALU_CTRL_DROP_CNT_EN
  logic [7:0]  DROP_CNT;
`endif

  int tests = 0;
  int fails = 0;
  int en_count = 0;
  int exp_drops = 0;
  logic [7:0] exp_q[$];

  alu_cmd_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .ALU_A    (ALU_A),
    .ALU_B    (ALU_B),
    .ALU_FUN  (ALU_FUN),
    .ALU_EN   (ALU_EN),
    .ALU_OUT  (ALU_OUT),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
`ifdef ALU_CTRL_DROP_CNT_EN
    .DROP_CNT (DROP_CNT),
`endif
    .BUSY     (BUSY)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ALU: result appears the cycle after ALU_EN.
  always @(posedge CLK or negedge RST) begin
    if (!RST) ALU_OUT <= 16'h0000;
    else if (ALU_EN) begin
      case (ALU_FUN)
        4'd0: ALU_OUT <= 16'(ALU_A) + 16'(ALU_B);
        4'd1: ALU_OUT <= 16'(ALU_A) - 16'(ALU_B);
        4'd2: ALU_OUT <= 16'(ALU_A) * 16'(ALU_B);
        4'd3: ALU_OUT <= (ALU_B != 0) ? 16'(ALU_A / ALU_B) : 16'h0000;
        4'd4: ALU_OUT <= 16'(ALU_A & ALU_B);
        4'd5: ALU_OUT <= 16'(ALU_A | ALU_B);
        default: ALU_OUT <= 16'h0000;
      endcase
    end
  end

  // Scoreboard: compare each transferred TX byte against the expected queue.
  always @(negedge CLK) begin
    if (RST && TX_VALID && TX_READY) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got %02h, expected no byte", TX_DATA);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (TX_DATA !== e) begin
          fails++;
          $display("FAIL tx_byte: got %02h, expected %02h", TX_DATA, e);
        end
      end
    end
    if (RST && ALU_EN === 1'b1) en_count++;
  end

  // Driver tasks
  task automatic send_rx(input logic [7:0] b);
    @(negedge CLK);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    send_rx(8'hCC);
    send_rx(a);
    send_rx(b);
    send_rx(f);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && BUSY === 1'b0) begin
        done = 1;
        break;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: queue=%0d busy=%b, expected queue=0 busy=0", name, exp_q.size(), BUSY);
      exp_q.delete();
    end
  endtask

  task automatic wait_tx_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (TX_VALID === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge CLK);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_tx_valid_timeout: TX_VALID=%b, expected 1", name, TX_VALID);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    tests++;
    if ({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY} !== '0) begin
      fails++;
      $display("FAIL %s: A=%02h B=%02h FUN=%h EN=%b TXD=%02h TXV=%b BUSY=%b, expected all 0",
               name, ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY);
    end
`ifdef ALU_CTRL_DROP_CNT_EN
    tests++;
    if (DROP_CNT !== 8'd0) begin
      fails++;
      $display("FAIL %s_drop_cnt: got %0d, expected 0", name, DROP_CNT);
    end
`endif
  endtask

  // Scenarios
  task automatic test_reset();
    RST = 1'b0; RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b1;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_add();
    int en0;
    en0 = en_count;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    send_frame(8'h05, 8'h03, 8'h00);
    tests++;
    if (ALU_EN !== 1'b1 || ALU_A !== 8'h05 || ALU_B !== 8'h03 || ALU_FUN !== 4'h0) begin
      fails++;
      $display("FAIL add_exec: EN=%b A=%02h B=%02h FUN=%h, expected EN=1 A=05 B=03 FUN=0",
               ALU_EN, ALU_A, ALU_B, ALU_FUN);
    end
    @(negedge CLK);
    tests++;
    if (ALU_EN !== 1'b0 || TX_VALID !== 1'b0) begin
      fails++;
      $display("FAIL add_capture: EN=%b TXV=%b, expected EN=0 TXV=0", ALU_EN, TX_VALID);
    end
    @(negedge CLK);
    tests++;
    if (TX_VALID !== 1'b1) begin
      fails++;
      $display("FAIL add_latency: TXV=%b, expected 1 three cycles after FUN", TX_VALID);
    end
    wait_idle("add");
    tests++;
    if (en_count - en0 !== 1) begin
      fails++;
      $display("FAIL add_en_pulses: got %0d, expected 1", en_count - en0);
    end
  endtask

  task automatic test_mul_sub();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    send_frame(8'h10, 8'h20, 8'h02);
    wait_idle("mul");
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFF);
    send_rx(8'hDD);
    send_rx(8'h01);
    wait_idle("sub");
    tests++;
    if (ALU_A !== 8'h10 || ALU_B !== 8'h20 || ALU_FUN !== 4'h1) begin
      fails++;
      $display("FAIL sub_operands: A=%02h B=%02h FUN=%h, expected A=10 B=20 FUN=1", ALU_A, ALU_B, ALU_FUN);
    end
  endtask

  task automatic test_backpressure();
    TX_READY = 1'b0;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    send_frame(8'h07, 8'h02, 8'h04);
    wait_tx_valid("bp");
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'h02) begin
        fails++;
        $display("FAIL bp_hold[%0d]: TXV=%b TXD=%02h, expected TXV=1 TXD=02", i, TX_VALID, TX_DATA);
      end
      @(negedge CLK);
    end
    TX_READY = 1'b1;
    wait_idle("bp");
  endtask

  task automatic test_abort();
    int en0;
    bit saw_tx;
    en0 = en_count;
    saw_tx = 0;
    send_frame(8'h01, 8'h02, 8'h15);
    exp_drops++;
    for (int i = 0; i < 6; i++) begin
      if (TX_VALID !== 1'b0) saw_tx = 1;
      @(negedge CLK);
    end
    tests++;
    if (saw_tx || BUSY !== 1'b0 || en_count != en0) begin
      fails++;
      $display("FAIL abort: saw_tx=%b BUSY=%b en_pulses=%0d, expected 0 0 0", saw_tx, BUSY, en_count - en0);
    end
    tests++;
    if (ALU_A !== 8'h01 || ALU_B !== 8'h02) begin
      fails++;
      $display("FAIL abort_operands: A=%02h B=%02h, expected A=01 B=02", ALU_A, ALU_B);
    end
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h00);
    send_frame(8'h01, 8'h02, 8'h00);
    wait_idle("after_abort");
  endtask

  task automatic test_drops();
    send_rx(8'h55);
    exp_drops++;
    tests++;
    if (BUSY !== 1'b0) begin
      fails++;
      $display("FAIL stray_byte: BUSY=%b, expected 0", BUSY);
    end
    TX_READY = 1'b0;
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h00);
    send_frame(8'h04, 8'h05, 8'h00);
    wait_tx_valid("drop");
    send_rx(8'h77);
    exp_drops++;
    tests++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'h09) begin
      fails++;
      $display("FAIL drop_in_send: TXV=%b TXD=%02h, expected TXV=1 TXD=09", TX_VALID, TX_DATA);
    end
    TX_READY = 1'b1;
    wait_idle("drop");
`ifdef ALU_CTRL_DROP_CNT_EN
    tests++;
    if (DROP_CNT !== 8'(exp_drops)) begin
      fails++;
      $display("FAIL drop_cnt: got %0d, expected %0d", DROP_CNT, exp_drops);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    send_rx(8'hCC);
    send_rx(8'h09);
    tests++;
    if (ALU_A !== 8'h09 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL mid_frame_load: A=%02h BUSY=%b, expected A=09 BUSY=1", ALU_A, BUSY);
    end
    RST = 1'b0;
    exp_drops = 0;
    #1;
    check_outputs_zero("mid_frame_reset");
    @(negedge CLK);
    RST = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    send_rx(8'hDD);
    send_rx(8'h00);
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_sub();
    test_backpressure();
    test_abort();
    test_drops();
    test_reset_mid_frame();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_bytes: %0d left in queue, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
